// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I ALU issue path.
// Opcodes, funct3/funct7 encodings and the issue_entry_t bundle.
package alu_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Order matches the ALU result mux.
    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } funct3_e;

    typedef struct packed {
        logic                funct7;
        logic [ALU_OP_W-1:0] alu_op;
        logic [XLEN-1:0]     operand_a;
        logic [XLEN-1:0]     operand_b;
        logic [4:0]          rd;
        logic                illegal;
    } issue_entry_t;

    function automatic logic [XLEN-1:0] sext12(
        input logic [11:0] imm
    );
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one OP / OP-IMM instruction into an issue entry.
// Ports: instr, rs1_data, rs2_data, wb_valid/wb_rd/wb_data in; entry out.
// ALU_ISSUE_FWD_EN: forward wb_data onto rs1/rs2 operands on a match.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]   instr,
    input  logic [31:0]   rs1_data,
    input  logic [31:0]   rs2_data,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    output issue_entry_t  entry
);

    logic [6:0] opcode;
    logic [6:0] f7;
    funct3_e    f3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        is_op;
    logic        is_imm;
    logic        is_shift;
    logic        is_arith;

    assign opcode = instr[6:0];
    assign f7     = instr[31:25];
    assign f3     = funct3_e'(instr[14:12]);

`ifdef ALU_ISSUE_FWD_EN
    logic wb_hit;
    assign wb_hit = wb_valid && (wb_rd != 5'd0);
    assign src_a  = (wb_hit && wb_rd == instr[19:15])
                  ? wb_data : rs1_data;
    assign src_b  = (wb_hit && wb_rd == instr[24:20])
                  ? wb_data : rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_valid, wb_rd, wb_data, instr[19:15]};
    assign src_a = rs1_data;
    assign src_b = rs2_data;
`endif

    assign is_op    = (opcode == OPC_OP);
    assign is_imm   = (opcode == OPC_OP_IMM);
    assign is_shift = is_imm && (f3 == SLL || f3 == SRL_SRA);
    assign is_arith = is_imm && !(f3 == SLL || f3 == SRL_SRA);

    always_comb begin
        entry           = '0;
        entry.alu_op    = instr[14:12];
        entry.operand_a = src_a;
        entry.operand_b = rs2_data;
        entry.rd        = instr[11:7];
        unique case (1'b1)
            is_op: begin
                entry.operand_b = src_b;
                entry.funct7    = instr[30];
                // The alternate encoding only exists for SUB and SRA.
                entry.illegal   = !(f7 == F7_BASE ||
                                    (f7 == F7_ALT &&
                                     (f3 == ADD_SUB ||
                                      f3 == SRL_SRA)));
            end
            is_shift: begin
                entry.operand_b = {27'b0, instr[24:20]};
                entry.funct7    = instr[30];
                if (f3 == SLL)
                    entry.illegal = (f7 != F7_BASE);
                else
                    entry.illegal = !(f7 == F7_BASE ||
                                      f7 == F7_ALT);
            end
            is_arith: begin
                // funct7 stays 0 so ADDI never turns into a subtract.
                entry.operand_b = sext12(instr[31:20]);
            end
            default: begin
                entry.illegal = 1'b1;
            end
        endcase
        if (entry.illegal)
            entry.rd = 5'd0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the RV32I ALU through a 2-entry skid buffer.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready with
// in_instr, in_rs1_data, in_rs2_data; wb_valid/wb_rd/wb_data forwarding;
// ex_valid/ex_ready with funct7, alu_op, operand_a, operand_b, ex_rd,
// ex_illegal. ALU_ISSUE_FWD_EN enables writeback forwarding.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [31:0]         in_rs1_data,
    input  logic [31:0]         in_rs2_data,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic [31:0]         wb_data,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic                funct7,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     operand_a,
    output logic [XLEN-1:0]     operand_b,
    output logic [4:0]          ex_rd,
    output logic                ex_illegal
);

    issue_entry_t dec;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    issue_entry_t main_n;
    issue_entry_t skid_n;
    logic         main_v;
    logic         skid_v;
    logic         main_v_n;
    logic         skid_v_n;
    logic         rdy_q;
    logic         accept;
    logic         drain;

    alu_issue_decode u_dec (
        .instr    (in_instr),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .entry    (dec)
    );

    assign accept = in_valid && rdy_q;
    assign drain  = main_v && ex_ready;

    always_comb begin
        main_n   = main_q;
        skid_n   = skid_q;
        main_v_n = main_v;
        skid_v_n = skid_v;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!main_v || drain) begin
            // Main frees up: refill from skid first, else from input.
            if (skid_v) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = 1'b0;
            end else begin
                main_v_n = accept;
                if (accept)
                    main_n = dec;
            end
        end else if (accept) begin
            skid_n   = dec;
            skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            main_q <= main_n;
            skid_q <= skid_n;
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            // Registered so in_ready never sees ex_ready combinationally.
            rdy_q  <= !skid_v_n;
        end
    end

    assign in_ready   = rdy_q;
    assign ex_valid   = main_v;
    assign funct7     = main_q.funct7;
    assign alu_op     = main_q.alu_op;
    assign operand_a  = main_q.operand_a;
    assign operand_b  = main_q.operand_b;
    assign ex_rd      = main_q.rd;
    assign ex_illegal = main_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the `funct7`, `alu_op`, `operand_a` and `operand_b` inputs for the RV32I ALU.
- Accepts raw instructions plus register-file read data over a valid/ready handshake.
- Decodes OP (0110011) and OP-IMM (0010011) instructions.
- Holds results in a registered 2-entry skid buffer, so the ALU side sees clean, stall-safe signals.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ALU_OP_W, 3, width of `alu_op`; equals funct3.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_rs1_data  in  32  register-file value for rs1.
- in_rs2_data  in  32  register-file value for rs2.
- wb_valid  in  1  writeback result valid (forwarding only).
- wb_rd  in  5  writeback destination (forwarding only).
- wb_data  in  32  writeback value (forwarding only).
- ex_valid  out  1  issued entry valid.
- ex_ready  in  1  ALU/EX stage accepts this cycle.
- funct7  out  1  add/sub and srl/sra select for the ALU.
- alu_op  out  3  ALU function select.
- operand_a  out  32  ALU operand A.
- operand_b  out  32  ALU operand B.
- ex_rd  out  5  destination register.
- ex_illegal  out  1  entry failed decode; the ALU result must be discarded.

Behaviour:
- Reset (rst_n=0 at a clock edge): ex_valid=0, in_ready=0 during reset and 1 from the first cycle after, funct7=0, alu_op=0, operand_a=0, operand_b=0, ex_rd=0, ex_illegal=0, both buffer entries invalid. Reset mid-transfer drops the entry silently.
- Handshakes: input transfer occurs when in_valid&in_ready; output transfer occurs when ex_valid&ex_ready. Outputs must hold stable while ex_valid&!ex_ready.
- Latency: an instruction accepted in cycle N is presented in cycle N+1 if the buffer was empty.
- Skid buffer: main entry drives the outputs; the skid entry captures the accepted instruction when main is occupied and not draining.
  - in_ready = !skid_valid, registered; in_ready never depends on ex_ready combinationally.
  - On a main drain with the skid full, skid moves to main in the same edge.
  - Simultaneous accept and drain with an empty skid: the new entry loads main directly.
  - Both entries full: in_ready=0; no acceptance until a drain.
- Decode rules:
  - alu_op = instr[14:12]; ex_rd = instr[11:7].
  - operand_a = rs1 data.
  - OP: operand_b = rs2 data; funct7 = instr[30].
  - OP-IMM: operand_b = sign-extended instr[31:20].
  - OP-IMM shifts (funct3 001/101): operand_b = {27'b0, instr[24:20]}; funct7 = instr[30].
  - Other OP-IMM: funct7 forced 0, so ADDI never subtracts even if imm[10]=1.
- Illegal (ex_illegal=1, operands still forwarded, ex_rd forced 0):
  - opcode not OP/OP-IMM;
  - OP with instr[31:25] not 0000000/0100000;
  - OP with 0100000 and funct3 not 000/101;
  - SLLI with instr[31:25]≠0;
  - SRLI/SRAI with instr[31:25] not 0000000/0100000.
- Flush:
  - Clears main and skid valid at the edge.
  - Has priority over a simultaneous accept; a concurrent input transfer is discarded.
  - in_ready is 1 the following cycle.
- rd=0 is legal and issues normally.

Optional Feature:
- ALU_ISSUE_FWD_EN defined: in the accept cycle, if wb_valid and wb_rd≠0 and wb_rd equals instr[19:15], operand_a takes wb_data instead of in_rs1_data.
  - Same rule applies to instr[24:20] for the OP operand_b; no effect on immediates.
- Undefined: wb_* ports are present but ignored; operands always come from in_rs*_data.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OPC_OP, OPC_OP_IMM;
  - funct3 enum (ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND=7), matching the ALU mux order;
  - funct7 constants F7_BASE, F7_ALT;
  - a packed issue_entry_t struct (funct7, alu_op, operand_a, operand_b, rd, illegal).
- One sub-module: alu_issue_decode, combinational instr/rs data → issue_entry_t. The top holds the skid buffer.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ex_ready=1 → next cycle: ex_valid=1, alu_op=0, funct7=0, operands 5/7, ex_rd=3.
- SUB 0x402081B3 → funct7=1.
- ADDI x1,x0,-1024 (imm=0xC00) → operand_b=0xFFFFFC00, funct7=0.
- SRAI x5,x6,4 (0x40435293) → operand_b=4, funct7=1, alu_op=5.
- ex_ready=0 for 3 cycles while issuing 3 back-to-back instructions:
  - in_ready drops after the 2nd accept;
  - outputs stay frozen on the 1st;
  - after ex_ready=1, instructions 1, 2, 3 emerge in order with none lost or duplicated.
- Opcode 0x0000006F (JAL) → ex_illegal=1, ex_rd=0.
- SLLI with instr[31:25]=0100000 → ex_illegal=1.
- Flush with both entries full and in_valid=1 → next cycle ex_valid=0, in_ready=1.
- Assert rst_n=0 mid-stall → all outputs zero at the next edge.
- (FWD_EN) wb_valid=1, wb_rd=1, wb_data=0xAA with ADD x3,x1,x2 → operand_a=0xAA.
